// File: rtl/write_line_pkg.sv
// write_line_pkg: constants and FSM state type shared by the RAM video line writer and reader
// Contents: line/burst geometry, external RAM address width, FSM state enum,
// and line_base(), the external RAM word address of the first pixel of a line.
package write_line_pkg;
  localparam int H_LEN = 640;
  localparam int BURST_LEN = 64;
  localparam int BURSTS = H_LEN / BURST_LEN;
  localparam int ADDR_W = 23;
  localparam int LB_AW = 10;
  localparam int BEAT_W = 6;
  localparam int BCNT_W = 4;
  typedef enum logic [1:0] {IDLE, REQ, BURST, WAIT_DONE} wl_state_t;
  // 640 * v_line, widened before the multiply so line 479 (306560) cannot truncate
  function automatic logic [ADDR_W-1:0] line_base(input logic [8:0] v);
    line_base = ADDR_W'(v) * ADDR_W'(H_LEN);
  endfunction
endpackage

// File: rtl/write_line_if.sv
// write_line_if: burst handshake and data bus between the line writer and the external RAM controller
// master (line writer): drives external_ram_write_address, start_external_ram_write,
//   Memory_Write_Data, WRITE; receives StartUploading, ReadyWrite.
// slave (RAM controller): the mirror image.
interface write_line_if;
  import write_line_pkg::*;
  logic [ADDR_W-1:0] external_ram_write_address;
  logic start_external_ram_write;
  logic StartUploading;
  logic ReadyWrite;
  logic [15:0] Memory_Write_Data;
  logic WRITE;
  modport master (
    output external_ram_write_address, start_external_ram_write, Memory_Write_Data, WRITE,
    input StartUploading, ReadyWrite
  );
  modport slave (
    input external_ram_write_address, start_external_ram_write, Memory_Write_Data, WRITE,
    output StartUploading, ReadyWrite
  );
endinterface

// File: rtl/write_req_edge.sv
// write_req_edge: rising-edge detector on a level request, using a registered copy of the level
// Ports: memory_clk, reset_n (async active-low), level (request in), rise (level high, copy low).
module write_req_edge (
  input  logic memory_clk,
  input  logic reset_n,
  input  logic level,
  output logic rise
);
  logic level_q;
  always_ff @(posedge memory_clk or negedge reset_n)
    if (!reset_n) level_q <= 1'b0;
    else level_q <= level;
  assign rise = level & ~level_q;
endmodule

// File: rtl/write_line.sv
// write_line: writes one 640-word line buffer line to external RAM as ten 64-word bursts
// Ports: memory_clk, reset_n (async active-low); Write_Line (rising edge starts a line),
//   v_line (line number, sampled on the start edge); line_buffer_read_address/_data
//   (1-cycle synchronous line buffer read); RAM_BUSY (line in progress);
//   ram (write_line_if.master: burst address/request, data, WRITE, StartUploading, ReadyWrite).
// Optional WRITE_LINE_OVERRUN_EN: adds line_overrun, a sticky flag for start edges while busy.
module write_line
  import write_line_pkg::*;
(
  input  logic             memory_clk,
  input  logic             reset_n,
  input  logic             Write_Line,
  input  logic [8:0]       v_line,
  input  logic [15:0]      line_buffer_read_data,
  output logic [LB_AW-1:0] line_buffer_read_address,
  output logic             RAM_BUSY,
`ifdef WRITE_LINE_OVERRUN_EN
  output logic             line_overrun,
`endif
  write_line_if.master     ram
);
  wl_state_t state;
  logic [BCNT_W-1:0] burst;
  logic start;
  write_req_edge u_edge (
    .memory_clk(memory_clk),
    .reset_n(reset_n),
    .level(Write_Line),
    .rise(start)
  );
  assign ram.Memory_Write_Data = line_buffer_read_data;
  // The low six bits of the read address double as the beat counter: the burst
  // ends on the cycle the address sits at burst*64+63, so it never passes 639.
  always_ff @(posedge memory_clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      burst <= '0;
      RAM_BUSY <= 1'b0;
      line_buffer_read_address <= '0;
      ram.external_ram_write_address <= '0;
      ram.start_external_ram_write <= 1'b0;
      ram.WRITE <= 1'b0;
    end else
      case (state)
        IDLE:
          if (start) begin
            state <= REQ;
            burst <= '0;
            RAM_BUSY <= 1'b1;
            line_buffer_read_address <= '0;
            ram.external_ram_write_address <= line_base(v_line);
            ram.start_external_ram_write <= 1'b1;
          end
        REQ:
          if (ram.StartUploading) begin
            state <= BURST;
            ram.start_external_ram_write <= 1'b0;
            ram.WRITE <= 1'b1;
          end
        BURST:
          if (&line_buffer_read_address[BEAT_W-1:0]) begin
            state <= WAIT_DONE;
            ram.WRITE <= 1'b0;
          end else line_buffer_read_address <= line_buffer_read_address + 1'b1;
        WAIT_DONE:
          if (ram.ReadyWrite) begin
            burst <= burst + 1'b1;
            ram.external_ram_write_address <= ram.external_ram_write_address + ADDR_W'(BURST_LEN);
            if (burst == BCNT_W'(BURSTS - 1)) begin
              state <= IDLE;
              RAM_BUSY <= 1'b0;
              line_buffer_read_address <= '0;
            end else begin
              state <= REQ;
              ram.start_external_ram_write <= 1'b1;
              line_buffer_read_address <= {burst + 1'b1, BEAT_W'(0)};
            end
          end
      endcase
`ifdef WRITE_LINE_OVERRUN_EN
  always_ff @(posedge memory_clk or negedge reset_n)
    if (!reset_n) line_overrun <= 1'b0;
    else if (start && RAM_BUSY) line_overrun <= 1'b1;
`endif
endmodule

// File: tb/tb_write_line.sv
// tb_write_line: directed self-checking bench for write_line with a line buffer and RAM controller model
module tb_write_line;
  import write_line_pkg::*;
  logic memory_clk = 1'b0;
  logic reset_n = 1'b0;
  logic Write_Line = 1'b0;
  logic [8:0] v_line = '0;
  logic [15:0] line_buffer_read_data = '0;
  logic [LB_AW-1:0] line_buffer_read_address;
  logic RAM_BUSY;
`ifdef WRITE_LINE_OVERRUN_EN
  logic line_overrun;
`endif
  int n_checks = 0;
  int n_fail = 0;
  write_line_if ram ();
  write_line dut (
    .memory_clk(memory_clk),
    .reset_n(reset_n),
    .Write_Line(Write_Line),
    .v_line(v_line),
    .line_buffer_read_data(line_buffer_read_data),
    .line_buffer_read_address(line_buffer_read_address),
    .RAM_BUSY(RAM_BUSY),
`ifdef WRITE_LINE_OVERRUN_EN
    .line_overrun(line_overrun),
`endif
    .ram(ram)
  );
  always #5 memory_clk = ~memory_clk;
  function automatic logic [15:0] pat(input logic [LB_AW-1:0] a);
    pat = {a[3:0], 2'b10, a} ^ 16'h5A3C;
  endfunction
  always @(posedge memory_clk) line_buffer_read_data <= pat(line_buffer_read_address);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_ext"}, 32'(ram.external_ram_write_address), 0);
    check({tag, "_req"}, 32'(ram.start_external_ram_write), 0);
    check({tag, "_write"}, 32'(ram.WRITE), 0);
    check({tag, "_lb"}, 32'(line_buffer_read_address), 0);
    check({tag, "_busy"}, 32'(RAM_BUSY), 0);
  endtask
  // One line with the controller answering after su_dly / rw_dly extra cycles.
  // repulse_b/spur_b/abort_b pick the burst for a Write_Line re-pulse, an early
  // ReadyWrite, or a mid-burst reset (-1 = none); both raises StartUploading with ReadyWrite.
  task automatic run_line(input int v, input int su_dly, input int rw_dly,
                          input int repulse_b, input int spur_b, input int abort_b, input bit both);
    int base;
    base = 640 * v;
    @(negedge memory_clk);
    check("idle_busy", 32'(RAM_BUSY), 0);
    v_line = 9'(v);
    Write_Line = 1'b1;
    @(negedge memory_clk);
    Write_Line = 1'b0;
    check("start_busy", 32'(RAM_BUSY), 1);
    for (int b = 0; b < 10; b++) begin
      check($sformatf("req_b%0d", b), 32'(ram.start_external_ram_write), 1);
      check($sformatf("ext_b%0d", b), 32'(ram.external_ram_write_address), 32'(base + 64 * b));
      check($sformatf("lb_req_b%0d", b), 32'(line_buffer_read_address), 32'(64 * b));
      for (int d = 0; d < su_dly; d++) begin
        @(negedge memory_clk);
        check($sformatf("req_hold_b%0d", b), 32'(ram.start_external_ram_write), 1);
        check($sformatf("ext_hold_b%0d", b), 32'(ram.external_ram_write_address), 32'(base + 64 * b));
      end
      ram.StartUploading = 1'b1;
      @(negedge memory_clk);
      ram.StartUploading = 1'b0;
      check($sformatf("write_e0_b%0d", b), 32'(ram.WRITE), 1);
      check($sformatf("req_low_b%0d", b), 32'(ram.start_external_ram_write), 0);
      check($sformatf("lb_e0_b%0d", b), 32'(line_buffer_read_address), 32'(64 * b));
      for (int j = 1; j <= 64; j++) begin
        if (b == abort_b && j == 30) begin
          reset_n = 1'b0;
          #1;
          check_reset_outputs("async_rst");
          ram.ReadyWrite = 1'b0;
          @(negedge memory_clk);
          @(negedge memory_clk);
          reset_n = 1'b1;
          return;
        end
        @(negedge memory_clk);
        check($sformatf("data_b%0d_k%0d", b, j - 1), 32'(ram.Memory_Write_Data), 32'(pat(10'(64 * b + j - 1))));
        if (j < 64) begin
          check($sformatf("write_b%0d_k%0d", b, j), 32'(ram.WRITE), 1);
          check($sformatf("lb_b%0d_k%0d", b, j), 32'(line_buffer_read_address), 32'(64 * b + j));
        end
        if (b == spur_b) ram.ReadyWrite = (j == 10);
        if (b == repulse_b) Write_Line = (j == 20);
      end
      check($sformatf("write_end_b%0d", b), 32'(ram.WRITE), 0);
      check($sformatf("lb_end_b%0d", b), 32'(line_buffer_read_address), 32'(64 * b + 63));
      for (int d = 0; d < rw_dly; d++) begin
        @(negedge memory_clk);
        check($sformatf("ext_wait_b%0d", b), 32'(ram.external_ram_write_address), 32'(base + 64 * b));
        check($sformatf("busy_wait_b%0d", b), 32'(RAM_BUSY), 1);
      end
      ram.ReadyWrite = 1'b1;
      ram.StartUploading = both;
      @(negedge memory_clk);
      ram.ReadyWrite = 1'b0;
      ram.StartUploading = 1'b0;
    end
    check("end_busy", 32'(RAM_BUSY), 0);
    check("end_req", 32'(ram.start_external_ram_write), 0);
    check("end_ext", 32'(ram.external_ram_write_address), 32'(base + 640));
  endtask
  initial begin
    ram.StartUploading = 1'b0;
    ram.ReadyWrite = 1'b0;
    repeat (3) @(negedge memory_clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge memory_clk);
    check_reset_outputs("post_reset");
    run_line(0, 0, 0, -1, -1, -1, 1'b0);
`ifdef WRITE_LINE_OVERRUN_EN
    check("overrun_clear", 32'(line_overrun), 0);
`endif
    run_line(479, 0, 0, -1, -1, -1, 1'b0);
    run_line(3, 5, 7, -1, -1, -1, 1'b1);
    run_line(10, 1, 2, 3, 6, -1, 1'b0);
`ifdef WRITE_LINE_OVERRUN_EN
    check("overrun_set", 32'(line_overrun), 1);
`endif
    run_line(7, 0, 0, -1, -1, 5, 1'b0);
    check_reset_outputs("after_abort");
`ifdef WRITE_LINE_OVERRUN_EN
    check("overrun_reset", 32'(line_overrun), 0);
`endif
    run_line(2, 0, 1, -1, -1, -1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
